fp_round_pipe: RTL
==================

Name: fp_round_pipe

Overview:
- Two-stage pipelined mantissa rounding unit for the FPU add/sub datapath.
- Takes a wide, MSB-aligned pre-rounding mantissa with sign and biased exponent, and rounds it to SIZE_MAN_RESULT bits under one of four IEEE-754 rounding modes.
- Propagates mantissa carry-out into the exponent and raises inexact/overflow flags.
- Sits between the normaliser and the result packer, with valid/ready flow control on both sides.

Parameters:
- SIZE_MAN, 32, input mantissa width, MSB-aligned; must be >= SIZE_MAN_RESULT+3.
- SIZE_MAN_RESULT, 23, output fraction width.
- SIZE_EXP, 8, biased exponent width.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous; clears both stages.
- i_valid  in  1  upstream data valid.
- o_ready  out  1  unit can accept i_* this cycle.
- i_sign  in  1  operand sign.
- i_exp  in  SIZE_EXP  biased exponent.
- i_man  in  SIZE_MAN  pre-rounding mantissa, hidden bit already removed.
- i_mode  in  2  0=RNE, 1=RTZ, 2=RUP (+inf), 3=RDN (-inf).
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts.
- o_sign  out  1  result sign.
- o_exp  out  SIZE_EXP  result exponent.
- o_man  out  SIZE_MAN_RESULT  rounded fraction.
- o_inexact  out  1  any discarded bit nonzero.
- o_overflow  out  1  rounding carried the exponent to all-ones.

Behaviour:
- Reset (async, i_rst=1): both stage valids = 0.
  - o_valid=0; o_sign, o_exp, o_man, o_inexact, o_overflow = 0.
  - o_ready=1 once reset is released.
- Field split:
  - Kept bits T = i_man[SIZE_MAN-1 : SIZE_MAN-SIZE_MAN_RESULT]; L = T[0].
  - G = next bit below T; R = bit below G; S = OR of all remaining lower bits.
- Stage 1 (register): capture sign, exp, T, mode, G, R, S. Compute:
  - inc: RNE = G&(R|S|L); RTZ = 0; RUP = ~sign&(G|R|S); RDN = sign&(G|R|S).
  - inexact = G|R|S.
  - special = (i_exp == all-ones). When special: inc=0, inexact=0, T passes through unchanged (Inf/NaN).
- Stage 2 (register): man = T + inc, computed in SIZE_MAN_RESULT+1 bits.
  - No carry: o_man = man[low], o_exp = exp.
  - Carry-out: o_man = 0, o_exp = exp+1.
  - If exp+1 == all-ones: o_overflow=1 and the result is infinity (exp all-ones, man 0). Increment only occurs toward larger magnitude, so infinity is correct for every mode.
  - o_sign = sign unchanged.
- Latency: exactly 2 cycles from acceptance (i_valid & o_ready) to o_valid when i_ready is held high. Throughput: 1 per cycle.
- Flow control:
  - s2_adv = ~s2_valid | i_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - o_ready = s1_adv (combinational from i_ready).
  - A stage holds its contents, and o_* stay stable, while o_valid & ~i_ready.
  - Max 2 entries in flight; no drop, no duplication, order preserved.
- Simultaneous accept and emit in the same cycle: both occur; full throughput is preserved.
- i_flush: next edge clears both valids. An input presented in the same cycle is discarded. Flush has priority over accept.
- Reset mid-operation: in-flight results are discarded immediately (async); o_valid falls without waiting for a clock edge.
- i_mode is sampled with the data at acceptance. A mode change between operands affects only subsequent operands.

Test Plan:
- RNE ties (defaults): T=23'h000001, i_man[8:0]=9'h100 -> o_man=23'h000002, inexact=1. T=23'h000002, same low bits -> o_man=23'h000002 (ties to even).
- Modes on T=23'h000010, low=9'h001, exp=8'h80:
  - sign=0: RUP -> 23'h000011; RDN and RTZ -> 23'h000010; RNE -> 23'h000010.
  - sign=1: RDN -> 23'h000011.
  - All cases: inexact=1.
- Carry-out and overflow, RNE, T=23'h7FFFFF, low=9'h1FF:
  - exp=8'h7E -> o_man=0, o_exp=8'h7F, overflow=0.
  - exp=8'hFE -> o_exp=8'hFF, o_man=0, overflow=1.
  - Same operand with RTZ -> o_man=23'h7FFFFF, o_exp=8'hFE, overflow=0.
- Special passthrough: exp=8'hFF, T=23'h400000, low=9'h1FF, RUP -> output unchanged, inexact=0, overflow=0.
- Backpressure: 5 back-to-back operands, i_ready=0 for cycles 2-5 -> o_ready low while both stages are full. All 5 emerge in order, o_* stable while stalled, latency 2 on the unstalled stream.
- Reset/flush:
  - Assert i_rst asynchronously with 2 entries in flight -> o_valid=0 immediately; nothing emitted after release.
  - Pulse i_flush with 2 in flight plus i_valid=1 -> no outputs from those 3 operands.

Source files
------------

// File: rtl/fp_round_pipe_if.sv
// Valid/ready handshake and operand/result bundle for the mantissa rounding pipe.
// The slave modport is the rounding unit; the master modport is the surrounding datapath.
interface fp_round_pipe_if #(
  parameter int SIZE_MAN        = 32,
  parameter int SIZE_MAN_RESULT = 23,
  parameter int SIZE_EXP        = 8
);
  logic                       i_flush;
  logic                       i_valid;
  logic                       o_ready;
  logic                       i_sign;
  logic [SIZE_EXP-1:0]        i_exp;
  logic [SIZE_MAN-1:0]        i_man;
  logic [1:0]                 i_mode;
  logic                       o_valid;
  logic                       i_ready;
  logic                       o_sign;
  logic [SIZE_EXP-1:0]        o_exp;
  logic [SIZE_MAN_RESULT-1:0] o_man;
  logic                       o_inexact;
  logic                       o_overflow;

  modport slave (
    input  i_flush, i_valid, i_sign, i_exp, i_man, i_mode, i_ready,
    output o_ready, o_valid, o_sign, o_exp, o_man, o_inexact, o_overflow
  );

  modport master (
    output i_flush, i_valid, i_sign, i_exp, i_man, i_mode, i_ready,
    input  o_ready, o_valid, o_sign, o_exp, o_man, o_inexact, o_overflow
  );
endinterface

// File: rtl/fp_round_pipe.sv
// Two-stage mantissa rounding pipe: stage 1 decides the increment, stage 2 applies it
// and folds any carry-out into the exponent.
module fp_round_pipe #(
  parameter int SIZE_MAN        = 32,
  parameter int SIZE_MAN_RESULT = 23,
  parameter int SIZE_EXP        = 8
) (
  input logic           i_clk,
  input logic           i_rst,
  fp_round_pipe_if.slave bus
);
  localparam int LOW = SIZE_MAN - SIZE_MAN_RESULT;

  logic                       s1_valid, s1_sign, s1_inc, s1_inexact;
  logic [SIZE_EXP-1:0]        s1_exp;
  logic [SIZE_MAN_RESULT-1:0] s1_t;

  logic                       s2_valid, s2_sign, s2_inexact, s2_overflow;
  logic [SIZE_EXP-1:0]        s2_exp;
  logic [SIZE_MAN_RESULT-1:0] s2_man;

  logic s1_adv, s2_adv;

  logic [SIZE_MAN_RESULT-1:0] in_t;
  logic                       in_g, in_r, in_s, in_any, in_special, in_inc, in_inexact;

  logic [SIZE_MAN_RESULT:0]   sum;
  logic [SIZE_EXP-1:0]        exp_inc, nx_exp;
  logic [SIZE_MAN_RESULT-1:0] nx_man;
  logic                       nx_overflow;

  assign s2_adv      = ~s2_valid | bus.i_ready;
  assign s1_adv      = ~s1_valid | s2_adv;
  assign bus.o_ready = s1_adv;

  always_comb begin
    in_t       = bus.i_man[SIZE_MAN-1 -: SIZE_MAN_RESULT];
    in_g       = bus.i_man[LOW-1];
    in_r       = bus.i_man[LOW-2];
    in_s       = |bus.i_man[LOW-3:0];
    in_any     = in_g | in_r | in_s;
    in_special = &bus.i_exp;
    in_inc     = 1'b0;
    case (bus.i_mode)
      2'd0:    in_inc = in_g & (in_r | in_s | in_t[0]);
      2'd1:    in_inc = 1'b0;
      2'd2:    in_inc = ~bus.i_sign & in_any;
      default: in_inc = bus.i_sign & in_any;
    endcase
    in_inexact = in_any;
    // Inf/NaN operands must pass through bit-exact.
    if (in_special) begin
      in_inc     = 1'b0;
      in_inexact = 1'b0;
    end
  end

  always_comb begin
    sum         = {1'b0, s1_t} + {{SIZE_MAN_RESULT{1'b0}}, s1_inc};
    exp_inc     = s1_exp + {{(SIZE_EXP-1){1'b0}}, 1'b1};
    nx_man      = sum[SIZE_MAN_RESULT-1:0];
    nx_exp      = s1_exp;
    nx_overflow = 1'b0;
    // Carry-out leaves the fraction at zero; reaching all-ones exponent is infinity.
    if (sum[SIZE_MAN_RESULT]) begin
      nx_man      = '0;
      nx_exp      = exp_inc;
      nx_overflow = (exp_inc == {SIZE_EXP{1'b1}});
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_exp      <= '0;
      s1_t        <= '0;
      s1_inc      <= 1'b0;
      s1_inexact  <= 1'b0;
      s2_valid    <= 1'b0;
      s2_sign     <= 1'b0;
      s2_exp      <= '0;
      s2_man      <= '0;
      s2_inexact  <= 1'b0;
      s2_overflow <= 1'b0;
    end else if (bus.i_flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= bus.i_valid;
      if (s1_adv && bus.i_valid) begin
        s1_sign    <= bus.i_sign;
        s1_exp     <= bus.i_exp;
        s1_t       <= in_t;
        s1_inc     <= in_inc;
        s1_inexact <= in_inexact;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        s2_sign     <= s1_sign;
        s2_exp      <= nx_exp;
        s2_man      <= nx_man;
        s2_inexact  <= s1_inexact;
        s2_overflow <= nx_overflow;
      end
    end
  end

  assign bus.o_valid    = s2_valid;
  assign bus.o_sign     = s2_sign;
  assign bus.o_exp      = s2_exp;
  assign bus.o_man      = s2_man;
  assign bus.o_inexact  = s2_inexact;
  assign bus.o_overflow = s2_overflow;
endmodule
